// File: rtl/serial_frame_sequencer_if.sv
// serial_frame_sequencer_if: request/payload inputs and serial frame outputs of the sequencer.
interface serial_frame_sequencer_if;
    logic        clkEn;
    logic        req0;
    logic        req1;
    logic [3:0]  len0;
    logic [3:0]  len1;
    logic [14:0] data0;
    logic [14:0] data1;
    logic [1:0]  gnt;
    logic        serOut;
    logic        serOutValid;
    logic [3:0]  countOut;
    logic        busy;
    logic        done;
    modport master (
        output clkEn, req0, req1, len0, len1, data0, data1,
        input  gnt, serOut, serOutValid, countOut, busy, done
    );
    modport slave (
        input  clkEn, req0, req1, len0, len1, data0, data1,
        output gnt, serOut, serOutValid, countOut, busy, done
    );
endinterface

// File: rtl/serial_frame_sequencer.sv
// serial_frame_sequencer: round-robin arbiter for two requesters that serialises preamble, length and payload.
module serial_frame_sequencer #(
    parameter logic [3:0] PRE_PATTERN = 4'b1011
) (
    input logic clk,
    input logic rst,
    serial_frame_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRE, LEN, DATA, DONE} state_t;
    state_t      state, stateNext;
    logic [1:0]  bitIdx, bitIdxNext;
    logic [3:0]  lenReg, lenNext;
    logic [14:0] shiftReg, shiftNext;
    logic [3:0]  count, countNext;
    logic        cur, curNext;
    logic        lastGnt, lastNext;
    logic        active;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bitIdx   <= 2'd3;
            lenReg   <= '0;
            shiftReg <= '0;
            count    <= '0;
            cur      <= 1'b0;
            lastGnt  <= 1'b1;
        end else begin
            state    <= stateNext;
            bitIdx   <= bitIdxNext;
            lenReg   <= lenNext;
            shiftReg <= shiftNext;
            count    <= countNext;
            cur      <= curNext;
            lastGnt  <= lastNext;
        end
    end
    always_comb begin
        stateNext  = state;
        bitIdxNext = bitIdx;
        lenNext    = lenReg;
        shiftNext  = shiftReg;
        countNext  = count;
        curNext    = cur;
        lastNext   = lastGnt;
        case (state)
            IDLE: if (bus.req0 || bus.req1) begin
                // a tie goes to whoever was not served last
                curNext    = (bus.req0 && bus.req1) ? ~lastGnt : bus.req1;
                lenNext    = curNext ? bus.len1 : bus.len0;
                shiftNext  = curNext ? bus.data1 : bus.data0;
                countNext  = lenNext;
                bitIdxNext = 2'd3;
                stateNext  = PRE;
            end
            PRE: if (bus.clkEn) begin
                bitIdxNext = bitIdx - 2'd1;
                stateNext  = (bitIdx == 2'd0) ? LEN : PRE;
            end
            LEN: if (bus.clkEn) begin
                bitIdxNext = bitIdx - 2'd1;
                stateNext  = (bitIdx != 2'd0) ? LEN : (lenReg != 4'd0) ? DATA : DONE;
            end
            DATA: if (bus.clkEn) begin
                shiftNext = {1'b0, shiftReg[14:1]};
                countNext = count - 4'd1;
                stateNext = (count == 4'd1) ? DONE : DATA;
            end
            DONE: begin
                lastNext  = cur;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end
    assign active          = (state == PRE) || (state == LEN) || (state == DATA);
    assign bus.gnt         = active ? (cur ? 2'b10 : 2'b01) : 2'b00;
    assign bus.serOut      = (state == PRE) ? PRE_PATTERN[bitIdx] :
                             (state == LEN) ? lenReg[bitIdx] :
                             (state == DATA) ? shiftReg[0] : 1'b0;
    assign bus.serOutValid = (state == DATA);
    assign bus.countOut    = active ? count : 4'd0;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
endmodule
